// File: rtl/logic_sweep_checker.sv
// Exhaustive sweep checker: drives 0..2^N_IN-1 to a logic unit and compares each result against a reference function.
// Latency: DUT_LAT+2 cycles per vector; done pulses the cycle after the final CHECK.
// No backpressure: start is accepted only in IDLE and is dropped otherwise. Optional macro LSC_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module logic_sweep_checker #(
    parameter int N_IN    = 3,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic [N_IN-1:0]   stim_out,
    input  logic              dut_result,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_valid
);

    localparam int PC_W = $clog2(N_IN + 1);
    localparam logic [3:0] WAIT_LOAD = (DUT_LAT > 0) ? 4'(DUT_LAT - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [N_IN-1:0]   fvec_q, fvec_d;
    logic              fvld_q, fvld_d;
    logic              pass_q, pass_d;
    logic [1:0]        mode_q, mode_d;

    logic [PC_W-1:0]   pop_c;
    logic              exp_c;
    logic              mismatch_c;
    logic              last_c;

    // Reference value for the vector currently on stim_out, using the mode latched at start.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < N_IN; i++) begin
            pop_c = pop_c + PC_W'(stim_q[i]);
        end
        case (mode_q)
            2'd0:    exp_c = &stim_q;
            2'd1:    exp_c = |stim_q;
            2'd2:    exp_c = ^stim_q;
            default: exp_c = (pop_c > PC_W'(N_IN / 2));
        endcase
    end

    // Sweep sequencing, mismatch accounting and result capture.
    always_comb begin
        state_d    = state_q;
        stim_d     = stim_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        fvec_d     = fvec_q;
        fvld_d     = fvld_q;
        pass_d     = pass_q;
        mode_d     = mode_q;
        mismatch_c = 1'b0;
        last_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    err_d   = '0;
                    fvld_d  = 1'b0;
                    pass_d  = 1'b0;
                    stim_d  = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (DUT_LAT == 0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CHECK: begin
                mismatch_c = (dut_result != exp_c);
                if (mismatch_c) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fvld_q) begin
                        fvec_d = stim_q;
                        fvld_d = 1'b1;
                    end
                end
                last_c = (stim_q == '1);
`ifdef LSC_STOP_ON_ERR_EN
                // Abort on the first mismatch; stim_out keeps the failing vector.
                last_c = last_c | mismatch_c;
`else
                // Full sweep always completes so every mismatch is counted.
                last_c = last_c;
`endif
                if (last_c) begin
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    stim_d  = stim_q + N_IN'(1);
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fvec_q  <= '0;
            fvld_q  <= 1'b0;
            pass_q  <= 1'b0;
            mode_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            fvld_q  <= fvld_d;
            pass_q  <= pass_d;
            mode_q  <= mode_d;
        end
    end

    assign stim_out        = stim_q;
    assign busy            = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign done            = (state_q == ST_DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_vec   = fvec_q;
    assign first_err_valid = fvld_q;

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Bench for logic_sweep_checker: one instance with zero DUT latency, one with three cycles.
// Expected values come from hand-computed timing and small reference models of the unit under test.
// Honours LSC_STOP_ON_ERR_EN when the bench is built with it.
module tb_logic_sweep_checker;

    logic       clk;
    logic       rst_n;
    int         checks;
    int         errors;

    // Instance with DUT_LAT=0
    logic       start0;
    logic [1:0] mode0;
    logic [2:0] stim0;
    logic       res0;
    logic       busy0, done0, pass0, fvld0;
    logic [7:0] err0;
    logic [2:0] fvec0;

    // Instance with DUT_LAT=3
    logic       start3;
    logic [1:0] mode3;
    logic [2:0] stim3;
    logic       res3;
    logic       busy3, done3, pass3, fvld3;
    logic [7:0] err3;
    logic [2:0] fvec3;

    // Model controls for instance 0: sel_and picks AND instead of XOR, bad0 flips chosen vectors
    logic       sel_and;
    logic [7:0] bad0;
    logic       p1, p2, p3;

    logic [2:0] hist[0:63];

    logic_sweep_checker #(.N_IN(3), .DUT_LAT(0), .ERR_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .stim_out(stim0),
        .dut_result(res0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_vec(fvec0), .first_err_valid(fvld0)
    );

    logic_sweep_checker #(.N_IN(3), .DUT_LAT(3), .ERR_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .stim_out(stim3),
        .dut_result(res3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_vec(fvec3), .first_err_valid(fvld3)
    );

    always #5 clk = ~clk;

    always_comb begin
        res0 = (sel_and ? (stim0[0] & stim0[1] & stim0[2]) : (stim0[0] ^ stim0[1] ^ stim0[2])) ^ bad0[stim0];
    end

    // Majority of three, delayed by three registers
    always @(posedge clk) begin
        p1 <= (stim3[0] & stim3[1]) | (stim3[0] & stim3[2]) | (stim3[1] & stim3[2]);
        p2 <= p1;
        p3 <= p2;
    end
    assign res3 = p3;

    // Pulses start on the chosen instance and records stim_out each cycle until done (cycle 1 = first after start edge)
    task automatic run_sweep(input int which, output int done_cyc);
        @(negedge clk);
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start3 = 1'b1;
        done_cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start0 = 1'b0;
            start3 = 1'b0;
            hist[c] = (which == 0) ? stim0 : stim3;
            if ((which == 0 && done0) || (which != 0 && done3)) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #7;
        checks++; if (stim0 !== 3'd0)  begin errors++; $display("FAIL reset_stim got %0d want 0", stim0); end
        checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy got %0b want 0", busy0); end
        checks++; if (done0 !== 1'b0)  begin errors++; $display("FAIL reset_done got %0b want 0", done0); end
        checks++; if (pass0 !== 1'b0)  begin errors++; $display("FAIL reset_pass got %0b want 0", pass0); end
        checks++; if (err0 !== 8'd0)   begin errors++; $display("FAIL reset_err got %0d want 0", err0); end
        checks++; if (fvec0 !== 3'd0)  begin errors++; $display("FAIL reset_fvec got %0d want 0", fvec0); end
        checks++; if (fvld0 !== 1'b0)  begin errors++; $display("FAIL reset_fvld got %0b want 0", fvld0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_xor_clean;
        int dc;
        int bad_steps;
        sel_and = 1'b0; bad0 = 8'h00; mode0 = 2'd2;
        run_sweep(0, dc);
        checks++; if (dc !== 17) begin errors++; $display("FAIL xor_done_cycle got %0d want 17", dc); end
        bad_steps = 0;
        for (int c = 1; c <= 16; c++) begin
            if (hist[c] !== 3'((c - 1) / 2)) bad_steps++;
        end
        checks++; if (bad_steps !== 0) begin errors++; $display("FAIL xor_stim_steps got %0d wrong cycles want 0", bad_steps); end
        checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL xor_pass got %0b want 1", pass0); end
        checks++; if (err0 !== 8'd0)  begin errors++; $display("FAIL xor_err got %0d want 0", err0); end
        checks++; if (fvld0 !== 1'b0) begin errors++; $display("FAIL xor_fvld got %0b want 0", fvld0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL xor_busy_at_done got %0b want 0", busy0); end
    endtask

    task automatic test_xor_errors;
        int dc;
        sel_and = 1'b0; bad0 = 8'b0110_0000; mode0 = 2'd2;
        run_sweep(0, dc);
`ifdef LSC_STOP_ON_ERR_EN
        checks++; if (err0 !== 8'd1)  begin errors++; $display("FAIL xerr_count got %0d want 1", err0); end
        checks++; if (stim0 !== 3'd5) begin errors++; $display("FAIL xerr_stim got %0d want 5", stim0); end
`else
        checks++; if (err0 !== 8'd2)  begin errors++; $display("FAIL xerr_count got %0d want 2", err0); end
`endif
        checks++; if (fvec0 !== 3'd5) begin errors++; $display("FAIL xerr_fvec got %0d want 5", fvec0); end
        checks++; if (fvld0 !== 1'b1) begin errors++; $display("FAIL xerr_fvld got %0b want 1", fvld0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL xerr_pass got %0b want 0", pass0); end
    endtask

    task automatic test_majority_lat3;
        int dc;
        int bad_steps;
        mode3 = 2'd3;
        run_sweep(3, dc);
        checks++; if (dc !== 41) begin errors++; $display("FAIL maj_done_cycle got %0d want 41", dc); end
        bad_steps = 0;
        for (int c = 1; c <= 40; c++) begin
            if (hist[c] !== 3'((c - 1) / 5)) bad_steps++;
        end
        checks++; if (bad_steps !== 0) begin errors++; $display("FAIL maj_stim_steps got %0d wrong cycles want 0", bad_steps); end
        checks++; if (pass3 !== 1'b1) begin errors++; $display("FAIL maj_pass got %0b want 1", pass3); end
        checks++; if (err3 !== 8'd0)  begin errors++; $display("FAIL maj_err got %0d want 0", err3); end
    endtask

    task automatic test_mode_toggle;
        int dc;
        sel_and = 1'b0; bad0 = 8'b0110_0000; mode0 = 2'd2;
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b1;
        dc = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start0 = 1'b0;
            if (c == 4) begin
                mode0  = 2'd0;
                start0 = 1'b1;
            end
            if (c == 5) begin
                checks++; if (busy0 !== 1'b1 || stim0 !== 3'd2) begin
                    errors++; $display("FAIL toggle_restart got busy=%0b stim=%0d want busy=1 stim=2", busy0, stim0);
                end
            end
            if (done0) begin dc = c; break; end
        end
        mode0 = 2'd2;
`ifdef LSC_STOP_ON_ERR_EN
        checks++; if (dc !== 13)     begin errors++; $display("FAIL toggle_done_cycle got %0d want 13", dc); end
        checks++; if (err0 !== 8'd1) begin errors++; $display("FAIL toggle_err got %0d want 1", err0); end
`else
        checks++; if (dc !== 17)     begin errors++; $display("FAIL toggle_done_cycle got %0d want 17", dc); end
        checks++; if (err0 !== 8'd2) begin errors++; $display("FAIL toggle_err got %0d want 2", err0); end
`endif
        checks++; if (fvec0 !== 3'd5) begin errors++; $display("FAIL toggle_fvec got %0d want 5", fvec0); end
    endtask

    task automatic test_reset_mid;
        int dc;
        int seen;
        sel_and = 1'b0; bad0 = 8'h00; mode0 = 2'd2;
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b1;
        seen = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start0 = 1'b0;
            if (stim0 == 3'd4) begin seen = 1; break; end
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL rstmid_reach4 got %0d want 1", seen); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({stim0, busy0, done0, pass0, err0, fvec0, fvld0} !== 18'd0) begin
            errors++; $display("FAIL rstmid_outputs got %h want 0", {stim0, busy0, done0, pass0, err0, fvec0, fvld0});
        end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d active cycles want 0", seen); end
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, dc);
        checks++; if (hist[1] !== 3'd0) begin errors++; $display("FAIL rstmid_fresh_stim got %0d want 0", hist[1]); end
        checks++; if (dc !== 17)        begin errors++; $display("FAIL rstmid_done_cycle got %0d want 17", dc); end
        checks++; if (pass0 !== 1'b1)   begin errors++; $display("FAIL rstmid_pass got %0b want 1", pass0); end
    endtask

    task automatic test_stop_on_err;
        int dc;
        sel_and = 1'b1; bad0 = 8'b0000_0100; mode0 = 2'd0;
        run_sweep(0, dc);
`ifdef LSC_STOP_ON_ERR_EN
        checks++; if (dc !== 7)       begin errors++; $display("FAIL stop_done_cycle got %0d want 7", dc); end
        checks++; if (stim0 !== 3'd2) begin errors++; $display("FAIL stop_stim got %0d want 2", stim0); end
`else
        checks++; if (dc !== 17)      begin errors++; $display("FAIL stop_done_cycle got %0d want 17", dc); end
        checks++; if (stim0 !== 3'd7) begin errors++; $display("FAIL stop_stim got %0d want 7", stim0); end
`endif
        checks++; if (err0 !== 8'd1)  begin errors++; $display("FAIL stop_err got %0d want 1", err0); end
        checks++; if (fvec0 !== 3'd2) begin errors++; $display("FAIL stop_fvec got %0d want 2", fvec0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL stop_pass got %0b want 0", pass0); end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        start0 = 1'b0; start3 = 1'b0; mode0 = 2'd2; mode3 = 2'd3;
        sel_and = 1'b0; bad0 = 8'h00;
        checks = 0; errors = 0;
        test_reset();
        test_xor_clean();
        test_xor_errors();
        test_majority_lat3();
        test_mode_toggle();
        test_reset_mid();
        test_stop_on_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
